// File: rtl/bcd_display_mux_pkg.sv
// Shared types and constants for the two-digit multiplexed BCD display driver.
// FSM state encoding plus active-high segment codes in {g,f,e,d,c,b,a} order.
package bcd_display_mux_pkg;

  typedef enum logic [1:0] {
    SHOW_T = 2'd0,
    GAP_T  = 2'd1,
    SHOW_O = 2'd2,
    GAP_O  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/bcd_display_mux_seven_seg_decode.sv
// Purely combinational BCD digit to seven-segment decoder.
// Non-BCD values 10..15 show the letter E.
module seven_seg_decode
  import bcd_display_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Map one BCD digit to its segment pattern.
  always_comb begin
    seg = SEG_E;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver with valid/ready input and
// frame-boundary update of the displayed pair (boundary = GAP_O cycle).
// Optional macro BCD_DISPLAY_MUX_LZ_BLANK_EN blanks a leading zero tens digit.
module bcd_display_mux
  import bcd_display_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [1:0] digit_en
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    disp_tens, disp_ones;
  logic [3:0]    pend_tens, pend_ones;
  logic          pend_v;
  logic [3:0]    dec_in;
  logic [6:0]    dec_seg;

  assign in_rdy = ~pend_v;

  // Single decoder shared by both digits; its input follows the FSM state.
  assign dec_in = (state == SHOW_T) ? disp_tens : disp_ones;

  seven_seg_decode u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  // FSM state and phase counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHOW_T;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pending/display pair: accept on handshake, promote at the frame boundary.
  // in_rdy = ~pend_v makes the two branches mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_tens <= '0;
      disp_ones <= '0;
      pend_tens <= '0;
      pend_ones <= '0;
      pend_v    <= 1'b0;
    end else if (in_val && in_rdy) begin
      pend_tens <= tens;
      pend_ones <= ones;
      pend_v    <= 1'b1;
    end else if (state == GAP_O && pend_v) begin
      disp_tens <= pend_tens;
      disp_ones <= pend_ones;
      pend_v    <= 1'b0;
    end
  end

  // Next-state logic and Moore outputs from registered state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    digit_en  = '0;
    seg       = SEG_OFF;
    case (state)
      SHOW_T: begin
`ifdef BCD_DISPLAY_MUX_LZ_BLANK_EN
        if (disp_tens != 4'd0) begin
          digit_en = 2'b10;
          seg      = dec_seg;
        end
`else
        digit_en = 2'b10;
        seg      = dec_seg;
`endif
        if (cnt == LAST) begin
          state_nxt = GAP_T;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP_T: state_nxt = SHOW_O;
      SHOW_O: begin
        digit_en = 2'b01;
        seg      = dec_seg;
        if (cnt == LAST) begin
          state_nxt = GAP_O;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP_O: state_nxt = SHOW_T;
      default: begin
        state_nxt = SHOW_T;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
